// File: rtl/af4eos_agg_wprt_bctrl.sv
// Write-side pointer controller for a dual-clock FIFO with burst writes, flush handshake and sticky overflow.
// Optional build macro AF4EOS_AGG_WPRT_OVF_CNT_EN adds a saturating refused-request counter output.
module af4eos_agg_wprt_bctrl #(
    parameter int ADDR = 8,
    parameter int DEP  = 256,
    parameter int WCW  = 2,
    parameter int SYNC = 2
) (
    input  logic            i_wclk,
    input  logic            i_wrst,
    input  logic            i_wen,
    input  logic [WCW-1:0]  i_wcnt,
    output logic            o_wack,
    output logic [ADDR-1:0] o_waddr,
    output logic [ADDR:0]   o_gwprt,
    input  logic [ADDR:0]   i_grprt,
    input  logic [ADDR:0]   i_wafthr,
    output logic            o_wfull,
    output logic            o_wafull,
    output logic [ADDR:0]   o_wlen,
    input  logic            i_wflush,
    output logic            o_wflush_done,
    output logic            o_wovf,
`ifdef AF4EOS_AGG_WPRT_OVF_CNT_EN
    output logic [15:0]     o_wovf_cnt,
`endif
    input  logic            i_wovf_clr
);

    localparam logic [ADDR:0] DEPV = (ADDR+1)'(DEP);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ADDR:0]   r_addr;
    logic [ADDR:0]   r_gaddr;
    logic [ADDR:0]   r_sync [SYNC];
    logic [ADDR:0]   r_wlen;
    logic            r_wfull;
    logic            r_wafull;
    logic            r_wovf;
    logic [ADDR:0]   w_brprt;
    logic [ADDR:0]   w_len;
    logic [ADDR:0]   w_free;
    logic [ADDR:0]   w_wcnt_ext;
    logic [ADDR:0]   w_nxt_addr;
    logic [ADDR:0]   w_nxt_len;
    logic            w_req;
    logic            w_acc;
    logic            w_ovf_set;

    function automatic logic [ADDR:0] bin2gray(input logic [ADDR:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR:0] gray2bin(input logic [ADDR:0] g);
        logic [ADDR:0] b;
        b[ADDR] = g[ADDR];
        for (int i = ADDR - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign w_brprt    = gray2bin(r_sync[SYNC-1]);
    assign w_len      = r_addr - w_brprt;
    assign w_free     = DEPV - w_len;
    assign w_wcnt_ext = (ADDR+1)'(i_wcnt);
    assign w_req      = i_wen & (i_wcnt != '0);
    assign w_acc      = w_req & (w_wcnt_ext <= w_free) & (r_state == IDLE);
    assign w_ovf_set  = w_req & ~w_acc & (r_state == IDLE);
    assign w_nxt_addr = r_addr + (w_acc ? w_wcnt_ext : '0);
    assign w_nxt_len  = w_nxt_addr - w_brprt;

    assign o_wack        = w_acc;
    assign o_waddr       = r_addr[ADDR-1:0];
    assign o_gwprt       = r_gaddr;
    assign o_wlen        = r_wlen;
    assign o_wfull       = r_wfull;
    assign o_wafull      = r_wafull;
    assign o_wovf        = r_wovf;
    assign o_wflush_done = (r_state == DONE);

    always_ff @(posedge i_wclk or negedge i_wrst) begin
        if (!i_wrst) begin
            r_addr   <= '0;
            r_gaddr  <= '0;
            r_wlen   <= '0;
            r_wfull  <= 1'b0;
            r_wafull <= 1'b0;
        end else begin
            r_addr   <= w_nxt_addr;
            r_gaddr  <= bin2gray(w_nxt_addr);
            r_wlen   <= w_nxt_len;
            r_wfull  <= (w_nxt_len == DEPV);
            r_wafull <= (w_nxt_len >= i_wafthr);
        end
    end

    // Read pointer crosses from the read domain through a plain flop chain.
    always_ff @(posedge i_wclk or negedge i_wrst) begin
        if (!i_wrst) begin
            for (int i = 0; i < SYNC; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_grprt;
            for (int i = 1; i < SYNC; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // A new overflow event beats a simultaneous clear.
    always_ff @(posedge i_wclk or negedge i_wrst) begin
        if (!i_wrst) begin
            r_wovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_wovf <= 1'b1;
        end else if (i_wovf_clr) begin
            r_wovf <= 1'b0;
        end
    end

`ifdef AF4EOS_AGG_WPRT_OVF_CNT_EN
    logic [15:0] r_wovf_cnt;

    always_ff @(posedge i_wclk or negedge i_wrst) begin
        if (!i_wrst) begin
            r_wovf_cnt <= '0;
        end else if (i_wovf_clr) begin
            r_wovf_cnt <= {15'd0, w_ovf_set};
        end else if (w_ovf_set && (r_wovf_cnt != 16'hFFFF)) begin
            r_wovf_cnt <= r_wovf_cnt + 16'd1;
        end
    end

    assign o_wovf_cnt = r_wovf_cnt;
`endif

    always_ff @(posedge i_wclk or negedge i_wrst) begin
        if (!i_wrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_wflush) w_state_nxt = DRAIN;
            DRAIN:   if (w_len == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_af4eos_agg_wprt_bctrl.sv
// Scoreboard bench for af4eos_agg_wprt_bctrl at ADDR=4/DEP=16: expected burst addresses and flush
// completions are queued by the stimulus and consumed by a monitor watching wack and wflush_done.
module tb_af4eos_agg_wprt_bctrl;

    localparam int ADDR = 4;
    localparam int DEP  = 16;
    localparam int WCW  = 2;
    localparam int SYNC = 2;

    logic            clk = 1'b0;
    logic            rstN;
    logic            wen;
    logic [WCW-1:0]  wcnt;
    logic            wack;
    logic [ADDR-1:0] waddr;
    logic [ADDR:0]   gwprt;
    logic [ADDR:0]   grprt;
    logic [ADDR:0]   wafthr;
    logic            wfull;
    logic            wafull;
    logic [ADDR:0]   wlen;
    logic            wflush;
    logic            wflushDone;
    logic            wovf;
    logic            wovfClr;
`ifdef AF4EOS_AGG_WPRT_OVF_CNT_EN
    logic [15:0]     wovfCnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [ADDR-1:0] ackQ [$];
    logic [ADDR:0]   doneQ [$];

    af4eos_agg_wprt_bctrl #(.ADDR(ADDR), .DEP(DEP), .WCW(WCW), .SYNC(SYNC)) dut (
        .i_wclk        (clk),
        .i_wrst        (rstN),
        .i_wen         (wen),
        .i_wcnt        (wcnt),
        .o_wack        (wack),
        .o_waddr       (waddr),
        .o_gwprt       (gwprt),
        .i_grprt       (grprt),
        .i_wafthr      (wafthr),
        .o_wfull       (wfull),
        .o_wafull      (wafull),
        .o_wlen        (wlen),
        .i_wflush      (wflush),
        .o_wflush_done (wflushDone),
        .o_wovf        (wovf),
`ifdef AF4EOS_AGG_WPRT_OVF_CNT_EN
        .o_wovf_cnt    (wovfCnt),
`endif
        .i_wovf_clr    (wovfClr)
    );

    // 10 ns write clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Issues one write request for a single cycle; accepted bursts queue their expected address.
    task automatic applyStimulus(input logic [WCW-1:0] cnt, input bit expAcc, input logic [ADDR-1:0] expAddr);
        if (expAcc) ackQ.push_back(expAddr);
        wen  = 1'b1;
        wcnt = cnt;
        @(posedge clk);
        #1;
        wen  = 1'b0;
        wcnt = '0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every acknowledge or flush completion must match a queued expectation.
    always @(negedge clk) begin
        if (rstN && wack) begin
            if (ackQ.size() == 0) begin
                checkOutput("unexpected wack", 1, 0);
            end else begin
                checkOutput("waddr on wack", int'(waddr), int'(ackQ.pop_front()));
            end
        end
        if (rstN && wflushDone) begin
            if (doneQ.size() == 0) begin
                checkOutput("unexpected wflush_done", 1, 0);
            end else begin
                checkOutput("wlen at wflush_done", int'(wlen), int'(doneQ.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rstN    = 1'b0;
        wen     = 1'b0;
        wcnt    = '0;
        grprt   = '0;
        wafthr  = 5'd12;
        wflush  = 1'b0;
        wovfClr = 1'b0;

        idleCycles(3);
        checkOutput("reset waddr", int'(waddr), 0);
        checkOutput("reset gwprt", int'(gwprt), 0);
        checkOutput("reset wlen", int'(wlen), 0);
        checkOutput("reset wfull", int'(wfull), 0);
        checkOutput("reset wafull", int'(wafull), 0);
        checkOutput("reset wovf", int'(wovf), 0);
        checkOutput("reset wflush_done", int'(wflushDone), 0);
        checkOutput("reset wack", int'(wack), 0);

        rstN = 1'b1;
        idleCycles(5);
        checkOutput("idle waddr", int'(waddr), 0);
        checkOutput("idle gwprt", int'(gwprt), 0);
        checkOutput("idle wlen", int'(wlen), 0);
        checkOutput("idle wovf", int'(wovf), 0);

        // Fill with five 3-word bursts; almost-full appears once the level reaches 12.
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(2'd3, 1'b1, 4'((k - 1) * 3));
            checkOutput("fill wlen", int'(wlen), 3 * k);
            checkOutput("fill wafull", int'(wafull), (3 * k >= 12) ? 1 : 0);
            checkOutput("fill wfull", int'(wfull), 0);
        end
        checkOutput("fill acks pending", ackQ.size(), 0);

        // One free slot: a 2-word burst is refused outright, a 1-word burst fits.
        applyStimulus(2'd2, 1'b0, 4'd0);
        checkOutput("boundary wovf", int'(wovf), 1);
        checkOutput("boundary wlen", int'(wlen), 15);
        applyStimulus(2'd1, 1'b1, 4'd15);
        checkOutput("boundary wfull", int'(wfull), 1);
        checkOutput("boundary wlen full", int'(wlen), 16);
        checkOutput("boundary acks pending", ackQ.size(), 0);

        applyStimulus(2'd1, 1'b0, 4'd0);
        checkOutput("full refusal wovf", int'(wovf), 1);
        checkOutput("full refusal wlen", int'(wlen), 16);
        wovfClr = 1'b1;
        idleCycles(1);
        wovfClr = 1'b0;
        checkOutput("wovf cleared", int'(wovf), 0);

        // Read side catches up to 16 (gray 5'b11000); level follows after SYNC+1 edges.
        grprt = 5'd24;
        idleCycles(2);
        checkOutput("drain latency wlen", int'(wlen), 16);
        idleCycles(1);
        checkOutput("drained wlen", int'(wlen), 0);
        checkOutput("drained wfull", int'(wfull), 0);
        checkOutput("drained wafull", int'(wafull), 0);

        // Pointer wraps past 16: 16 -> 19, gray(19) = 26.
        applyStimulus(2'd3, 1'b1, 4'd0);
        checkOutput("wrap gwprt", int'(gwprt), 26);
        checkOutput("wrap wlen", int'(wlen), 3);

        applyStimulus(2'd3, 1'b1, 4'd3);
        applyStimulus(2'd2, 1'b1, 4'd6);
        checkOutput("pre-flush wlen", int'(wlen), 8);
        checkOutput("pre-flush acks pending", ackQ.size(), 0);

        // Flush: writes refused silently until the read side empties the FIFO.
        wflush = 1'b1;
        idleCycles(1);
        wflush = 1'b0;
        applyStimulus(2'd1, 1'b0, 4'd0);
        checkOutput("flush refusal wovf", int'(wovf), 0);
        checkOutput("flush refusal wlen", int'(wlen), 8);
        idleCycles(3);
        checkOutput("flush still draining", doneQ.size(), 0);

        // grprt to 24 (gray 5'b10100) empties the FIFO.
        doneQ.push_back(5'd0);
        grprt = 5'd20;
        idleCycles(7);
        checkOutput("flush done pending", doneQ.size(), 0);
        checkOutput("post-flush wlen", int'(wlen), 0);

        applyStimulus(2'd1, 1'b1, 4'd8);
        checkOutput("post-flush wlen after write", int'(wlen), 1);
        idleCycles(2);
        checkOutput("final acks pending", ackQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
